pipe_skid_stage: RTL and testbench
==================================

Name: pipe_skid_stage

Overview:
Parametrised elastic pipeline register that succeeds the fixed enable/clear stage flops.
- Carries an arbitrary-width payload between two core stages using a valid/ready handshake.
- Holds a 2-entry skid buffer so `in_ready` is purely registered; stalls no longer form a combinational chain back through the pipeline.
- Provides synchronous flush for branch/jump squash, plus a saturating back-pressure counter for debug.

Parameters:
- DATA_W, 32, payload width in bits; the caller packs the control and data fields.
- RESET_DATA, '0, value loaded into the main and skid entries on reset and on a clearing flush.
- CLEAR_ON_FLUSH, 1, 1 = flush also loads RESET_DATA into both entries; 0 = flush invalidates only.
- CNT_W, 16, width of the stall counter.

Ports:
- clk, input, 1, rising-edge clock.
- reset, input, 1, synchronous reset, active low.
- flush, input, 1, synchronous squash of all held entries.
- in_valid, input, 1, upstream offers in_data.
- in_ready, output, 1, stage can accept; registered (state != FULL).
- in_data, input, DATA_W, upstream payload.
- out_valid, output, 1, out_data is valid (state != EMPTY).
- out_ready, input, 1, downstream accepts.
- out_data, output, DATA_W, main-entry contents, driven directly from a flop.
- occupancy, output, 2, number of held entries: 0, 1 or 2.
- stall_cnt, output, CNT_W, saturating count of cycles with out_valid & !out_ready.

Behaviour:
Interface:
- One clock. Reset is synchronous and active-low; the ports are named clk and reset, the same as the existing stage flops.

Definitions:
- accept = in_valid & in_ready.
- fire = out_valid & out_ready.

States:
- EMPTY: occupancy 0.
- HALF: main entry valid, occupancy 1.
- FULL: main and skid entries valid, occupancy 2.

Reset:
- Applies when reset is 0 at a clk edge.
- State goes to EMPTY; main and skid load RESET_DATA; stall_cnt goes to 0.
- Resulting outputs: in_ready = 1, out_valid = 0, out_data = RESET_DATA, occupancy = 0.
- Reset mid-transfer drops all held data; no partial state survives.

Priority: reset > flush > normal operation.

Flush (reset = 1, flush = 1):
- State goes to EMPTY.
- Both entries load RESET_DATA if CLEAR_ON_FLUSH = 1; otherwise they are unchanged.
- An accept in the same cycle is discarded.
- A fire in the same cycle is legal; downstream still consumes the current out_data.
- stall_cnt is not cleared.

Transitions (no reset, no flush):
- EMPTY:
  - accept: main <= in_data, go to HALF.
  - fire cannot occur.
- HALF:
  - accept & fire: main <= in_data, stay in HALF (full throughput).
  - accept & !fire: skid <= in_data, go to FULL.
  - !accept & fire: go to EMPTY.
  - otherwise: hold.
- FULL (in_ready = 0, so no accept):
  - fire: main <= skid, go to HALF.
  - otherwise: hold.

Ordering and timing:
- Data order is strictly FIFO; no payload is dropped or duplicated except by reset or flush.
- Latency: in_data accepted at edge N appears on out_data after edge N, when the stage was EMPTY or was HALF with a fire.
- Steady-state throughput with out_ready held at 1 is one transfer per cycle.
- While out_valid = 1 and no fire occurs, out_data stays stable.
- out_valid never drops without a fire, a flush or a reset.

stall_cnt:
- Increments by 1 each cycle with out_valid & !out_ready.
- Saturates at 2^CNT_W − 1 with no wrap.
- Sampled out_valid is the pre-edge value.

Illegal input: in_valid must not depend combinationally on in_ready. This is not checked in RTL; the bench asserts it.

Decomposition:
- Package pipe_pkg holds:
  - typedef enum logic [1:0] skid_state_t {EMPTY, HALF, FULL}.
  - localparam OCC_W = 2.
- One sub-module is natural: sat_counter.
  - Parameter W.
  - Ports: clk, reset, inc, count.
  - Instantiated for stall_cnt.
- Core stages keep their own packed structs and pass $bits(struct) as DATA_W.

Test Plan:
1. Reset/idle: reset = 0 for 2 cycles, then 1, with DATA_W = 32 and RESET_DATA = 0 → in_ready = 1, out_valid = 0, out_data = 0, occupancy = 0, stall_cnt = 0.
2. Streaming: out_ready = 1, push 0x11, 0x22, 0x33 on consecutive cycles → out_data shows 0x11, 0x22, 0x33 one cycle after each push; occupancy stays 1; in_ready stays 1.
3. Back-pressure/skid: out_ready = 0, push 0xA1 then 0xA2 → occupancy 2, in_ready = 0 and a third push of 0xA3 is not accepted, stall_cnt increments each cycle. Then out_ready = 1 → outputs 0xA1, then 0xA2, then occupancy 0.
4. Flush: hold 0xB1 and 0xB2 (FULL), assert flush together with in_valid carrying 0xB3 → next cycle EMPTY, out_valid = 0, out_data = 0; 0xB3 is never output; stall_cnt is retained.
5. Saturation: CNT_W = 4, out_valid = 1 and out_ready = 0 for 20 cycles → stall_cnt stops at 15.
6. Reset mid-operation: FULL with 0xC1 and 0xC2, assert reset = 0 for 1 cycle → EMPTY, stall_cnt = 0; after release, pushing 0xC3 outputs 0xC3 first.

Source files
------------

// File: rtl/pipe_pkg.sv
// Shared types for the elastic skid pipeline stage.
package pipe_pkg;

  localparam int OCC_W = 2;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    HALF  = 2'd1,
    FULL  = 2'd2
  } skid_state_t;

  // Number of held entries implied by a state.
  function automatic logic [OCC_W-1:0] occ_of(skid_state_t s);
    case (s)
      HALF:    occ_of = OCC_W'(1);
      FULL:    occ_of = OCC_W'(2);
      default: occ_of = OCC_W'(0);
    endcase
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter: sticks at all-ones instead of wrapping.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         inc,
  output logic [W-1:0] count
);

  // Count qualifying cycles, holding at the maximum value.
  always_ff @(posedge clk) begin
    if (!reset)                  count <= '0;
    else if (inc && count != '1) count <= count + W'(1);
  end

endmodule

// File: rtl/pipe_skid_stage.sv
// Elastic pipeline register with a 2-entry skid buffer. in_ready, out_valid
// and occupancy all come straight from flops, so downstream stalls never
// ripple combinationally back into upstream stages.
module pipe_skid_stage
  import pipe_pkg::*;
#(
  parameter int                DATA_W         = 32,
  parameter logic [DATA_W-1:0] RESET_DATA     = '0,
  parameter bit                CLEAR_ON_FLUSH = 1'b1,
  parameter int                CNT_W          = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [OCC_W-1:0]  occupancy,
  output logic [CNT_W-1:0]  stall_cnt
);

  skid_state_t       state_q, state_d;
  logic [DATA_W-1:0] main_q, main_d;
  logic [DATA_W-1:0] skid_q, skid_d;
  logic              in_ready_q, out_valid_q;
  logic [OCC_W-1:0]  occ_q;
  logic              accept, fire;

  assign accept    = in_valid & in_ready_q;
  assign fire      = out_valid_q & out_ready;

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_data  = main_q;
  assign occupancy = occ_q;

  // Next-state / next-entry selection; flush squashes everything held and
  // drops a same-cycle accept, while a same-cycle fire just consumes main.
  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    if (flush) begin
      state_d = EMPTY;
      if (CLEAR_ON_FLUSH) begin
        main_d = RESET_DATA;
        skid_d = RESET_DATA;
      end
    end else begin
      case (state_q)
        EMPTY: begin
          if (accept) begin
            main_d  = in_data;
            state_d = HALF;
          end
        end
        HALF: begin
          if (accept && fire) begin
            main_d  = in_data;
          end else if (accept) begin
            skid_d  = in_data;
            state_d = FULL;
          end else if (fire) begin
            state_d = EMPTY;
          end
        end
        FULL: begin
          if (fire) begin
            main_d  = skid_q;
            state_d = HALF;
          end
        end
        default: state_d = EMPTY;
      endcase
    end
  end

  // State, entries and the handshake outputs, all registered from next state.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= EMPTY;
      main_q      <= RESET_DATA;
      skid_q      <= RESET_DATA;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      occ_q       <= '0;
    end else begin
      state_q     <= state_d;
      main_q      <= main_d;
      skid_q      <= skid_d;
      in_ready_q  <= (state_d != FULL);
      out_valid_q <= (state_d != EMPTY);
      occ_q       <= occ_of(state_d);
    end
  end

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (out_valid_q & ~out_ready),
    .count (stall_cnt)
  );

endmodule

// File: tb/tb_pipe_skid_stage.sv
// Bench for pipe_skid_stage: a queue-based reference model checked every
// cycle, plus directed scenarios with literal expectations.
module tb_pipe_skid_stage;

  localparam int DATA_W = 32;
  localparam int CNT_W  = 4;
  localparam int SMAX   = (1 << CNT_W) - 1;

  logic              clk = 1'b0;
  logic              reset, flush, in_valid, out_ready;
  logic [DATA_W-1:0] in_data;
  logic              in_ready, out_valid;
  logic [DATA_W-1:0] out_data;
  logic [1:0]        occupancy;
  logic [CNT_W-1:0]  stall_cnt;

  int checks   = 0;
  int failures = 0;

  pipe_skid_stage #(
    .DATA_W(DATA_W), .RESET_DATA('0), .CLEAR_ON_FLUSH(1'b1), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .occupancy(occupancy), .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: an ordered list of held payloads (capacity 2).
  logic [DATA_W-1:0] q[$];
  int  m_stall = 0;
  bit  m_live  = 1'b0;

  always @(posedge clk) begin
    int  sz;
    bit  mv, mr;
    sz = q.size();
    mv = (sz > 0);
    mr = (sz < 2);
    if (!reset) begin
      q.delete();
      m_stall = 0;
      m_live  = 1'b1;
    end else begin
      if (mv && !out_ready && m_stall < SMAX) m_stall++;
      if (flush) q.delete();
      else begin
        if (mv && out_ready) void'(q.pop_front());
        if (in_valid && mr)  q.push_back(in_data);
      end
    end
  end

  // Per-cycle comparison against the model, just after each edge.
  always @(posedge clk) begin
    #1;
    if (m_live) begin
      check("m_in_ready",  in_ready,  q.size() < 2);
      check("m_out_valid", out_valid, q.size() > 0);
      check("m_occupancy", occupancy, q.size());
      check("m_stall_cnt", stall_cnt, m_stall);
      if (q.size() > 0) check("m_out_data", out_data, q[0]);
    end
  end

  // One cycle: drive on the falling edge, return just after the rising edge.
  task automatic step(input logic rst_n, input logic fl, input logic iv,
                      input logic [DATA_W-1:0] d, input logic ordy);
    @(negedge clk);
    reset = rst_n; flush = fl; in_valid = iv; in_data = d; out_ready = ordy;
    @(posedge clk);
    #2;
  endtask

  initial begin
    reset = 1'b0; flush = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;

    // 1. reset / idle
    step(0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0);
    check("rst_in_ready",  in_ready,  1);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_data",  out_data,  0);
    check("rst_occupancy", occupancy, 0);
    check("rst_stall_cnt", stall_cnt, 0);

    // 2. streaming at full throughput
    step(1, 0, 1, 32'h11, 1);
    check("strm_d0", out_data, 32'h11); check("strm_occ0", occupancy, 1);
    step(1, 0, 1, 32'h22, 1);
    check("strm_d1", out_data, 32'h22); check("strm_rdy1", in_ready, 1);
    step(1, 0, 1, 32'h33, 1);
    check("strm_d2", out_data, 32'h33); check("strm_occ2", occupancy, 1);
    step(1, 0, 0, 0, 1);
    check("strm_drain", out_valid, 0);

    // 3. back-pressure into the skid entry
    step(1, 0, 1, 32'hA1, 0);
    step(1, 0, 1, 32'hA2, 0);
    check("bp_occ_full", occupancy, 2); check("bp_rdy_low", in_ready, 0);
    step(1, 0, 1, 32'hA3, 0);
    check("bp_hold_d", out_data, 32'hA1); check("bp_stall", stall_cnt, 2);
    step(1, 0, 0, 0, 1);
    check("bp_out_a2", out_data, 32'hA2); check("bp_occ1", occupancy, 1);
    step(1, 0, 0, 0, 1);
    check("bp_empty", occupancy, 0);

    // 4. flush while FULL with a colliding push
    step(1, 0, 1, 32'hB1, 0);
    step(1, 0, 1, 32'hB2, 0);
    step(1, 1, 1, 32'hB3, 0);
    check("fl_valid", out_valid, 0); check("fl_data", out_data, 0);
    check("fl_occ", occupancy, 0);   check("fl_stall_kept", stall_cnt, 4);
    step(1, 0, 0, 0, 1);
    check("fl_no_b3", out_valid, 0);

    // 5. stall counter saturation
    step(1, 0, 1, 32'hD1, 0);
    for (int i = 0; i < 20; i++) step(1, 0, 0, 0, 0);
    check("sat_max", stall_cnt, 15);
    step(1, 0, 0, 0, 1);
    check("sat_drain", occupancy, 0);

    // 6. reset in the middle of a FULL hold
    step(1, 0, 1, 32'hC1, 0);
    step(1, 0, 1, 32'hC2, 0);
    check("mr_full", occupancy, 2);
    step(0, 0, 0, 0, 0);
    check("mr_occ", occupancy, 0); check("mr_stall", stall_cnt, 0);
    check("mr_data", out_data, 0); check("mr_rdy", in_ready, 1);
    step(1, 0, 1, 32'hC3, 1);
    check("mr_first_c3", out_data, 32'hC3); check("mr_valid", out_valid, 1);
    step(1, 0, 0, 0, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Safety net so the run always terminates.
  initial begin
    #100000;
    failures++;
    $display("FAIL timeout: got no completion expected completion");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
